// File: rtl/sysctrl_pkg.sv
// Shared command codes, protocol constants and helpers for the sysctrl_cfg block.
package sysctrl_pkg;

  typedef enum logic [7:0] {
    CMD_STATUS   = 8'h00,
    CMD_LEDS     = 8'h01,
    CMD_COLOR    = 8'h02,
    CMD_BUTTONS  = 8'h03,
    CMD_CFG_WR   = 8'h04,
    CMD_IRQ      = 8'h05,
    CMD_CFG_RD   = 8'h06,
    CMD_IRQ_MASK = 8'h07
  } cmd_e;

  localparam logic [7:0] MAGIC0      = 8'h5C;
  localparam logic [7:0] MAGIC1      = 8'h42;
  localparam logic [7:0] CFG_ID_BASE = 8'h41;

  // MSB<->LSB swap; the ws2812 colour bytes arrive bit-reversed
  function automatic logic [7:0] bit_rev8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/sysctrl_debounce.sv
// Per-button 2-FF synchroniser plus stability counter (built only with SYSCTRL_DEBOUNCE_EN).
`ifdef SYSCTRL_DEBOUNCE_EN
module sysctrl_debounce #(
  parameter logic [15:0] DEB_CYCLES = 16'd50000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic btn_db
);

  logic        s1;
  logic        s2;
  logic [15:0] cnt;

  // Output flips only after DEB_CYCLES consecutive differing samples
  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      btn_db <= 1'b0;
      cnt    <= '0;
    end else begin
      s1 <= btn;
      s2 <= s1;
      if (s2 == btn_db) begin
        cnt <= '0;
      end else if (cnt >= DEB_CYCLES - 16'd1) begin
        btn_db <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule
`endif

// File: rtl/sysctrl_cfg.sv
// MCU byte-stream command decoder: config slots, maskable latched interrupts, LEDs/colour/buttons.
// Define SYSCTRL_DEBOUNCE_EN to debounce the button inputs returned by the buttons command.
module sysctrl_cfg
  import sysctrl_pkg::*;
#(
  parameter logic [7:0]           CORE_ID      = 8'h02,
  parameter int unsigned          NUM_CFG      = 16,
  parameter logic [NUM_CFG*8-1:0] CFG_DEFAULTS = {NUM_CFG{8'h00}},
  parameter int unsigned          INT_W        = 8,
  parameter int unsigned          NUM_BTN      = 2,
  parameter logic [15:0]          DEB_CYCLES   = 16'd50000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     data_in_strobe,
  input  logic                     data_in_start,
  input  logic [7:0]               data_in,
  output logic [7:0]               data_out,
  output logic                     int_out_n,
  input  logic [INT_W-1:0]         int_in,
  output logic [INT_W-1:0]         int_ack,
  input  logic [NUM_BTN-1:0]       buttons,
  output logic [1:0]               leds,
  output logic [23:0]              color,
  output logic [NUM_CFG*8-1:0]     cfg_flat,
  output logic                     cfg_wr,
  output logic [((NUM_CFG > 1) ? $clog2(NUM_CFG) : 1)-1:0] cfg_wr_idx
);

  localparam int unsigned IDX_W = (NUM_CFG > 1) ? $clog2(NUM_CFG) : 1;

  logic [3:0]           cnt;
  logic [7:0]           cmd;
  logic [7:0]           cfg_id;
  logic [NUM_CFG*8-1:0] cfg_q;
  logic [INT_W-1:0]     int_q;
  logic [INT_W-1:0]     pending;
  logic [INT_W-1:0]     mask;
  logic [NUM_BTN-1:0]   btn_v;

  logic                 payload_c;
  logic [7:0]           slot_c;
  logic                 slot_ok_c;
  logic [7:0]           rbit_c;
  logic [7:0]           cfg_rd_c;
  logic [7:0]           reply_c;
  logic [INT_W-1:0]     ack_c;
  logic [INT_W-1:0]     edge_c;

  // Payload decode and reply byte selection
  always_comb begin
    payload_c = data_in_strobe && !data_in_start && (cnt != 4'd0);
    slot_c    = cfg_id - CFG_ID_BASE;
    slot_ok_c = slot_c < 8'(NUM_CFG);
    rbit_c    = bit_rev8(data_in);
    edge_c    = int_in & ~int_q;
    ack_c     = '0;
    cfg_rd_c  = 8'h00;
    reply_c   = 8'h00;
    for (int i = 0; i < NUM_CFG; i++) begin
      if (slot_c == 8'(i)) cfg_rd_c = cfg_q[8*i +: 8];
    end
    if (payload_c && (cmd == CMD_IRQ) && (cnt == 4'd1)) ack_c = data_in[INT_W-1:0];
    case (cmd)
      CMD_STATUS: begin
        case (cnt)
          4'd1:    reply_c = MAGIC0;
          4'd2:    reply_c = MAGIC1;
          4'd3:    reply_c = CORE_ID;
          4'd4:    reply_c = 8'(NUM_CFG);
          default: reply_c = 8'h00;
        endcase
      end
      CMD_BUTTONS: reply_c = 8'(btn_v);
      CMD_IRQ:     reply_c = 8'(pending & mask);
      CMD_CFG_RD:  if (cnt >= 4'd2) reply_c = cfg_rd_c;
      default:     reply_c = 8'h00;
    endcase
  end

  // Frame tracking, register bank and interrupt state
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      cmd        <= '0;
      cfg_id     <= '0;
      data_out   <= '0;
      leds       <= '0;
      color      <= '0;
      cfg_q      <= CFG_DEFAULTS;
      cfg_wr     <= 1'b0;
      cfg_wr_idx <= '0;
      int_q      <= '0;
      pending    <= '0;
      mask       <= '1;
      int_ack    <= '0;
      int_out_n  <= 1'b1;
    end else begin
      int_q     <= int_in;
      pending   <= (pending & ~ack_c) | edge_c;
      int_out_n <= ~|(pending & mask);
      int_ack   <= ack_c;
      cfg_wr    <= 1'b0;
      if (data_in_strobe && data_in_start) begin
        cnt <= 4'd1;
        cmd <= data_in;
      end else if (payload_c) begin
        if (cnt != 4'd15) cnt <= cnt + 4'd1;
        data_out <= reply_c;
        case (cmd)
          CMD_LEDS: if (cnt == 4'd1) leds <= data_in[1:0];
          CMD_COLOR: begin
            case (cnt)
              4'd1:    color[15:8]  <= rbit_c;
              4'd2:    color[7:0]   <= rbit_c;
              4'd3:    color[23:16] <= rbit_c;
              default: ;
            endcase
          end
          CMD_CFG_WR: begin
            if (cnt == 4'd1) begin
              cfg_id <= data_in;
            end else if ((cnt == 4'd2) && slot_ok_c) begin
              for (int i = 0; i < NUM_CFG; i++) begin
                if (slot_c == 8'(i)) cfg_q[8*i +: 8] <= data_in;
              end
              cfg_wr     <= 1'b1;
              cfg_wr_idx <= IDX_W'(slot_c);
            end
          end
          CMD_CFG_RD:   if (cnt == 4'd1) cfg_id <= data_in;
          CMD_IRQ_MASK: if (cnt == 4'd1) mask <= data_in[INT_W-1:0];
          default: ;
        endcase
      end
    end
  end

  assign cfg_flat = cfg_q;

`ifdef SYSCTRL_DEBOUNCE_EN
  for (genvar b = 0; b < NUM_BTN; b++) begin : g_deb
    sysctrl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk    (clk),
      .reset  (reset),
      .btn    (buttons[b]),
      .btn_db (btn_v[b])
    );
  end
`else
  logic [NUM_BTN-1:0] btn_s1;
  logic [NUM_BTN-1:0] btn_s2;

  // Synchroniser only; no debounce counter in this build
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
    end else begin
      btn_s1 <= buttons;
      btn_s2 <= btn_s1;
    end
  end

  assign btn_v = btn_s2;
`endif

endmodule

// File: doc/sysctrl_cfg.md
Name: sysctrl_cfg

Overview:
- Generic MCU-facing system control block. It is the byte-stream command decoder between the MCU SPI receiver and the core.
- Holds a parametrised bank of user config slots written by the OSD, with readback and a per-slot change strobe.
- Provides latched, maskable interrupts over INT_W sources, plus LEDs, RGB colour and button status.
- Core-agnostic: core identity and config defaults come from parameters.

Parameters:
- CORE_ID, 8'h02, core id returned by status command.
- NUM_CFG, 16, number of 8-bit config slots, 1..26.
- CFG_DEFAULTS, {NUM_CFG{8'h00}}, flat NUM_CFG*8 reset values; slot i is bits [8i+7:8i].
- INT_W, 8, interrupt source count, 1..8.
- NUM_BTN, 2, button inputs, 1..8.
- DEB_CYCLES, 16'd50000, debounce stability window in clk cycles; used only with SYSCTRL_DEBOUNCE_EN.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous, active-high.
- data_in_strobe, in, 1, one-cycle pulse when a received byte is valid.
- data_in_start, in, 1, qualifies the strobed byte as a command byte (first of frame).
- data_in, in, 8, received byte.
- data_out, out, 8, reply byte.
- int_out_n, out, 1, active-low interrupt to MCU.
- int_in, in, INT_W, interrupt request levels from core.
- int_ack, out, INT_W, one-cycle acknowledge pulse per source.
- buttons, in, NUM_BTN, raw button levels.
- leds, out, 2, MCU-driven LEDs.
- color, out, 24, RGB for ws2812.
- cfg_flat, out, NUM_CFG*8, all config slots, slot i at [8i+7:8i].
- cfg_wr, out, 1, one-cycle pulse after a slot is written.
- cfg_wr_idx, out, $clog2(NUM_CFG) (min 1), index of the written slot.

Behaviour:
- Reset values:
  - Frame counter and data_out: 0.
  - leds: 0. color: 0.
  - cfg_flat: CFG_DEFAULTS.
  - int pending, int_ack, cfg_wr, cfg_wr_idx: 0.
  - int mask: all ones.
  - Debounced buttons: 0.
- Frame counter `cnt` (4 bit) and `cmd` (8 bit):
  - A strobe with start sets cnt=1 and cmd=data_in. This always restarts the frame, including mid-frame.
  - A strobe without start when cnt!=0 processes payload byte number cnt, then increments cnt; cnt saturates at 15.
  - A strobe without start when cnt==0 is ignored.
  - All register updates occur on the strobe cycle and are visible the following cycle.
- Commands (payload index = cnt):
  - 0 status: data_out = 8'h5C, 8'h42, CORE_ID, NUM_CFG at indices 1..4; 0 afterwards.
  - 1 leds: index 1 sets leds=data_in[1:0].
  - 2 color: data_in is bit-reversed first. Index 1 -> color[15:8], index 2 -> color[7:0], index 3 -> color[23:16].
  - 3 buttons: every payload byte sets data_out = zero-extended button vector (debounced if the feature is on).
  - 4 cfg write:
    - Index 1 latches id.
    - Index 2: slot = id-8'h41 ('A'). If slot<NUM_CFG, write data_in to that slot, then cfg_wr=1 and cfg_wr_idx=slot on the next cycle.
    - Out-of-range id: no write, no pulse.
  - 5 irq: index 1 drives int_ack = data_in[INT_W-1:0] for one cycle and clears those pending bits. Every payload byte sets data_out = zero-extended (pending & mask), sampled before the clear.
  - 6 cfg read: index 1 latches id. Index 2 and later return the slot value, or 8'h00 if out of range.
  - 7 irq mask: index 1 sets mask = data_in[INT_W-1:0].
  - Any other cmd: payload ignored; data_out = 0.
- Interrupts:
  - int_in is registered once. pending[i] is set on a 0->1 edge of int_in[i].
  - A set and an ack on the same cycle: set wins.
  - int_out_n = ~|(pending & mask), registered.
  - Masked bits keep latching and appear on unmask.
- cfg_wr and int_ack are single-cycle pulses and return to 0 otherwise.
- Reset mid-frame: all state returns to reset values; the next byte is ignored unless it carries start.

Optional Feature:
- Macro SYSCTRL_DEBOUNCE_EN.
- Defined: each button passes a 2-FF synchroniser plus a counter. The debounced value changes only after the synchronised input differs from it for DEB_CYCLES consecutive clocks; any bounce reloads the counter. Command 3 and nothing else uses the debounced value.
- Undefined: command 3 returns buttons through the 2-FF synchroniser only; no counter logic is synthesised.

Decomposition:
- Package sysctrl_pkg: command codes (CMD_STATUS=0 … CMD_IRQ_MASK=7), the magic bytes 8'h5C/8'h42, and the cfg id base 8'h41.
- One sub-module, sysctrl_debounce: per-button synchroniser and counter, instantiated NUM_BTN times via generate. Present only under the macro.

Test Plan:
- Status frame: reset, send start 8'h00 then 4 payload bytes -> data_out 5C, 42, 02, 10 (NUM_CFG=16), then 00.
- Cfg write/read:
  - Write start 04, "C", 8'h03 -> cfg_flat[23:16]=03; cfg_wr pulses one cycle with idx=2.
  - Write start 06, "C", xx -> data_out=03.
  - Write id "Z" -> no write, no pulse; a cfg read of "Z" returns 00.
- Interrupt latch/ack: pulse int_in[1] for one cycle -> int_out_n=0. Frame 05, 8'h02 -> int_ack=02 for one cycle, data_out=02, int_out_n returns to 1.
- Mask and simultaneous set/ack: mask=8'h00 (cmd 07), raise int_in[0] -> int_out_n stays 1; unmask -> int_out_n=0. Ack bit0 on the same cycle as a new edge on int_in[0] -> pending stays 1.
- Frame restart and reset: after cmd 02 byte 1, issue start 01 with payload 8'h03 -> leds=3, color[23:16] unchanged. Assert reset mid cmd-04 frame -> next non-start byte ignored, cfg_flat=CFG_DEFAULTS.
- Color and debounce:
  - Cmd 02 with 8'h01, 8'h80, 8'hFF -> color=24'hFF_80_01.
  - With SYSCTRL_DEBOUNCE_EN and DEB_CYCLES=8: a button glitch of 5 cycles -> cmd 03 reads 00; a 10-cycle press -> reads 01.
